// File: rtl/adc_frame_tx_pkg.sv
// Shared definitions for the ADC result framer: FSM encoding, frame constants
// and the 8-bit wrapping checksum helper.
package adc_frame_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam int unsigned FRAME_LEN      = 4;
    localparam logic [1:0]  LAST_IDX       = 2'(FRAME_LEN - 1);
    localparam logic [7:0]  DEFAULT_HEADER = 8'hA5;

    function automatic logic [7:0] checksum8(input logic [7:0] b0,
                                             input logic [7:0] b1,
                                             input logic [7:0] b2);
        logic [7:0] sum_s;
        sum_s = b0 + b1 + b2;
        return sum_s;
    endfunction

endpackage

// File: rtl/ff_buffer.sv
// Enable-gated capture register with asynchronous active-low clear.
module ff_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_d;
    logic [W-1:0] q_q;

    // Load on enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // Capture register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/adc_frame_tx.sv
// Packs one SAR result into a header/high/low/checksum UART frame, sequenced
// by the transmitter's stt/eot handshake. All outputs are registered.
module adc_frame_tx
    import adc_frame_tx_pkg::*;
#(
    parameter int unsigned Width  = 10,
    parameter logic [7:0]  Header = DEFAULT_HEADER
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [Width-1:0] data_i,
    input  logic             eot_i,
    output logic             stt_o,
    output logic [7:0]       byte_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    state_e           state_d, state_q;
    logic [1:0]       idx_d, idx_q;
    logic [7:0]       byte_d, byte_q;
    logic             stt_d, stt_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;
    logic             overrun_d, overrun_q;
    logic             accept_s;
    logic [1:0]       nxt_idx_s;
    logic [Width-1:0] cap_s;

    // Frame byte selected by index; the high byte is zero-extended above Width.
    function automatic logic [7:0] frame_byte(input logic [1:0]       idx,
                                              input logic [Width-1:0] d);
        logic [15:0] ext_s;
        logic [7:0]  res_s;
        ext_s = 16'(d);
        case (idx)
            2'd0:    res_s = Header;
            2'd1:    res_s = ext_s[15:8];
            2'd2:    res_s = ext_s[7:0];
            default: res_s = checksum8(Header, ext_s[15:8], ext_s[7:0]);
        endcase
        return res_s;
    endfunction

    // A new frame is taken only when idle or in the done cycle.
    assign accept_s  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign nxt_idx_s = idx_q + 2'd1;

    ff_buffer #(
        .W (Width)
    ) u_capture (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .en_i   (accept_s),
        .d_i    (data_i),
        .q_o    (cap_s)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        byte_d    = byte_q;
        stt_d     = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_SEND;
                    idx_d   = 2'd0;
                    byte_d  = Header;
                    stt_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_SEND: begin
                state_d   = ST_WAIT;
                overrun_d = start_i;
            end
            ST_WAIT: begin
                // A dropped start is flagged on the cycle after it arrives.
                overrun_d = start_i;
                if (eot_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        idx_d   = nxt_idx_s;
                        byte_d  = frame_byte(nxt_idx_s, cap_s);
                        stt_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= 2'd0;
            byte_q    <= 8'd0;
            stt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            byte_q    <= byte_d;
            stt_q     <= stt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign stt_o     = stt_q;
    assign byte_o    = byte_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_adc_frame_tx.sv
// Directed, table-driven bench for adc_frame_tx with a transmitter model that
// returns eot_i five cycles after each stt_o.
module tb_adc_frame_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       start_i;
    logic [9:0] data_i;
    logic       eot_i;
    logic       stt_o;
    logic [7:0] byte_o;
    logic       busy_o;
    logic       done_o;
    logic       overrun_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [9:0] data;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
    } vec_t;

    vec_t vecs [4];

    adc_frame_tx #(
        .Width  (10),
        .Header (8'hA5)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .data_i    (data_i),
        .eot_i     (eot_i),
        .stt_o     (stt_o),
        .byte_o    (byte_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_stt();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (stt_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("stt_wait", 32'(ok), 32'd1);
    endtask

    // One full frame; options add a dropped start, stray eot, chained start.
    task automatic run_frame(input vec_t v, input bit ovr, input bit stray,
                             input bit pre, input bit chain, input logic [9:0] nxt);
        logic [7:0] exp_b;
        if (!pre) begin
            data_i  = v.data;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            check("stt_first", 32'(stt_o), 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       exp_b = 8'hA5;
                1:       exp_b = v.b1;
                2:       exp_b = v.b2;
                default: exp_b = v.b3;
            endcase
            wait_stt();
            check($sformatf("byte%0d", k), 32'(byte_o), 32'(exp_b));
            check("busy_in_frame", 32'(busy_o), 32'd1);
            for (int w = 0; w < 4; w++) begin
                if (stray && w == 0) eot_i = 1'b1;
                if (ovr && k == 1 && w == 1) begin
                    start_i = 1'b1;
                    data_i  = ~v.data;
                end
                tick();
                eot_i   = 1'b0;
                start_i = 1'b0;
                check("stt_gap", 32'(stt_o), 32'd0);
                if (ovr && k == 1 && w == 1) check("overrun_hi", 32'(overrun_o), 32'd1);
                if (ovr && k == 1 && w == 2) check("overrun_lo", 32'(overrun_o), 32'd0);
            end
            check($sformatf("byte%0d_held", k), 32'(byte_o), 32'(exp_b));
            eot_i = 1'b1;
            tick();
            eot_i = 1'b0;
        end
        check("done_pulse", 32'(done_o), 32'd1);
        check("busy_at_done", 32'(busy_o), 32'd0);
        check("stt_at_done", 32'(stt_o), 32'd0);
        if (chain) begin
            data_i  = nxt;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            check("chain_stt", 32'(stt_o), 32'd1);
            check("chain_byte", 32'(byte_o), 32'hA5);
            check("chain_no_overrun", 32'(overrun_o), 32'd0);
            check("chain_busy", 32'(busy_o), 32'd1);
        end else begin
            tick();
            check("done_once", 32'(done_o), 32'd0);
            check("busy_after", 32'(busy_o), 32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{data: 10'h2C7, b1: 8'h02, b2: 8'hC7, b3: 8'h6E};
        vecs[1] = '{data: 10'h3FF, b1: 8'h03, b2: 8'hFF, b3: 8'hA7};
        vecs[2] = '{data: 10'h000, b1: 8'h00, b2: 8'h00, b3: 8'hA5};
        vecs[3] = '{data: 10'h155, b1: 8'h01, b2: 8'h55, b3: 8'hFB};

        rst_i   = 1'b0;
        start_i = 1'b0;
        data_i  = 10'h000;
        eot_i   = 1'b0;
        tick();
        tick();
        check("rst_stt", 32'(stt_o), 32'd0);
        check("rst_byte", 32'(byte_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        rst_i = 1'b1;
        tick();

        eot_i = 1'b1;
        tick();
        eot_i = 1'b0;
        check("idle_eot_stt", 32'(stt_o), 32'd0);
        check("idle_eot_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        end

        run_frame(vecs[0], 1'b1, 1'b0, 1'b0, 1'b0, 10'h000);

        run_frame(vecs[1], 1'b0, 1'b0, 1'b0, 1'b1, vecs[3].data);
        run_frame(vecs[3], 1'b0, 1'b0, 1'b1, 1'b0, 10'h000);

        run_frame(vecs[2], 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);

        // Reset asserted mid-cycle while waiting on B2's eot.
        data_i  = 10'h2C7;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int b = 0; b < 2; b++) begin
            repeat (4) tick();
            eot_i = 1'b1;
            tick();
            eot_i = 1'b0;
        end
        check("pre_rst_stt", 32'(stt_o), 32'd1);
        check("pre_rst_byte", 32'(byte_o), 32'hC7);
        tick();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_byte", 32'(byte_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_stt", 32'(stt_o), 32'd0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        tick();
        for (int n = 0; n < 10; n++) begin
            if (n == 3) eot_i = 1'b1;
            tick();
            eot_i = 1'b0;
            check("post_rst_stt", 32'(stt_o), 32'd0);
            check("post_rst_busy", 32'(busy_o), 32'd0);
        end
        run_frame(vecs[0], 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
